// File: rtl/string_reader.sv
// UART-to-line receiver: 8N1 deserialiser feeding a line assembler that presents
// right-aligned packed lines (last char at [7:0]) on a valid/ready handshake.
module string_reader #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_CHARS = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [MAX_CHARS*8-1:0] line,
  output logic [7:0]             line_len,
  output logic                   line_trunc,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic                   frame_err,
  output logic [1:0]             rx_state
);

  localparam int CPB = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int W   = MAX_CHARS * 8;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [7:0]    MAX_CNT   = 8'(MAX_CHARS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  // Handshake: a line transfers on any rising edge where line_valid && line_ready.
  // line/line_len/line_trunc are held stable while line_valid is high and not yet taken.

  logic            rx_meta_q;
  logic            rx_sync_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;

  logic            byte_ok;
  logic [7:0]      byte_val;
  logic            is_eol;

  logic [W-1:0]    asm_q, asm_d;
  logic [7:0]      count_q, count_d;
  logic            trunc_q, trunc_d;
  logic [W-1:0]    line_q, line_d;
  logic [7:0]      len_q, len_d;
  logic            ltrunc_q, ltrunc_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit recheck rejects short low glitches.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            frame_err_q <= !rx_sync_q;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte strobe fires on the stop-bit sample edge so the line can register in that same edge.
  assign byte_ok  = (state_q == S_STOP) && (cnt_q == CNT_LAST) && rx_sync_q;
  assign byte_val = shift_q;
  assign is_eol   = (byte_val == 8'h0D) || (byte_val == 8'h0A);

  always_comb begin
    asm_d    = asm_q;
    count_d  = count_q;
    trunc_d  = trunc_q;
    line_d   = line_q;
    len_d    = len_q;
    ltrunc_d = ltrunc_q;
    valid_d  = valid_q;
    if (valid_q && line_ready) valid_d = 1'b0;
    if (byte_ok) begin
      if (is_eol) begin
        if (count_q != 8'd0) begin
          if (!valid_q || line_ready) begin
            line_d   = asm_q;
            len_d    = count_q;
            ltrunc_d = trunc_q;
            valid_d  = 1'b1;
          end
          asm_d   = '0;
          count_d = 8'd0;
          trunc_d = 1'b0;
        end
      end else if (byte_val != 8'h00) begin
        if (count_q < MAX_CNT) begin
          asm_d   = {asm_q[W-9:0], byte_val};
          count_d = count_q + 8'd1;
        end else begin
          trunc_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q    <= '0;
      count_q  <= 8'd0;
      trunc_q  <= 1'b0;
      line_q   <= '0;
      len_q    <= 8'd0;
      ltrunc_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      count_q  <= count_d;
      trunc_q  <= trunc_d;
      line_q   <= line_d;
      len_q    <= len_d;
      ltrunc_q <= ltrunc_d;
      valid_q  <= valid_d;
    end
  end

  assign line       = line_q;
  assign line_len   = len_q;
  assign line_trunc = ltrunc_q;
  assign line_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign rx_state   = state_q;

endmodule
